// File: rtl/mxu_axil_pkg.sv
// mxu_axil_pkg: shared AXI4-Lite response codes, master FSM states and default protection bits
package mxu_axil_pkg;
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;
    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA
    } mst_state_t;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/mxu_axil_wdog.sv
// mxu_axil_wdog: counts cycles while en (cleared by clr), raises sticky hang at TIMEOUT; ports clk, reset(active-low), clr, en -> hang
module mxu_axil_wdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hang
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            hang <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != CW'(TIMEOUT)) begin
            cnt  <= cnt + CW'(1);
            hang <= hang || cnt == CW'(TIMEOUT - 1);
        end
    end
endmodule

// File: rtl/mxu_axil_master.sv
// mxu_axil_master: single-outstanding AXI4-Lite initiator; cmd_* in, resp_*/busy/hang out, AW/W/B/AR/R master channels
module mxu_axil_master
    import mxu_axil_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_code,
    output logic                busy,
    output logic                hang,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [2:0]          awprot,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    output logic [2:0]          arprot,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
);
    mst_state_t state, state_next;
    logic cmd_fire, b_fire, r_fire;
    assign cmd_ready = state == IDLE;
    assign busy      = !cmd_ready;
    assign arvalid   = state == RD_REQ;
    assign bready    = state == WR_RESP;
    assign rready    = state == RD_DATA;
    assign awprot    = AXI_PROT_DEFAULT;
    assign arprot    = AXI_PROT_DEFAULT;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign b_fire    = bready && bvalid;
    assign r_fire    = rready && rvalid;
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = cmd_valid ? (cmd_write ? WR_REQ : RD_REQ) : IDLE;
            WR_REQ:  state_next = ((!awvalid || awready) && (!wvalid || wready)) ? WR_RESP : WR_REQ;
            WR_RESP: state_next = bvalid ? IDLE : WR_RESP;
            RD_REQ:  state_next = arready ? RD_DATA : RD_REQ;
            RD_DATA: state_next = rvalid ? IDLE : RD_DATA;
            default: state_next = IDLE;
        endcase
    end
    // AW and W are retired independently; each valid falls on its own handshake
    always_ff @(posedge clk) begin
        if (!reset) begin
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_code  <= '0;
            awaddr     <= '0;
            araddr     <= '0;
            wdata      <= '0;
            wstrb      <= '0;
        end else begin
            awvalid    <= cmd_fire ? cmd_write : awvalid && !awready;
            wvalid     <= cmd_fire ? cmd_write : wvalid && !wready;
            resp_valid <= b_fire || r_fire;
            if (cmd_fire) begin
                awaddr <= cmd_addr;
                araddr <= cmd_addr;
                wdata  <= cmd_wdata;
                wstrb  <= cmd_wstrb;
            end
            if (b_fire || r_fire) begin
                resp_rdata <= r_fire ? rdata : '0;
                resp_code  <= r_fire ? rresp : bresp;
            end
        end
    end
    mxu_axil_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk  (clk),
        .reset(reset),
        .clr  (state_next != state),
        .en   (state != IDLE),
        .hang (hang)
    );
endmodule

// File: tb/tb_mxu_axil_master.sv
// tb_mxu_axil_master: vector table, randomized transactions against a latency/response model, and corner-case sequences
module tb_mxu_axil_master;
    localparam int TMO = 8;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        resp_valid, busy, hang;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_code;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0, rready;
    int          vectors = 0, miscompares = 0;
    bit          hang_model = 1'b0;
    mxu_axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_code(resp_code),
        .busy(busy), .hang(hang),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awprot(awprot),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arprot(arprot),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );
    always #5 clk = ~clk;
    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_code;
        int          exp_lat;
    } vec_t;
    function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] wd, logic [3:0] ws,
                                int awd, int wdd, int bd, int ard, int rdd, logic [1:0] rs,
                                logic [31:0] rd, logic [31:0] er, logic [1:0] ec, int el);
        vec_t v;
        v.write = w; v.addr = a; v.wd = wd; v.ws = ws;
        v.aw_d = awd; v.w_d = wdd; v.b_d = bd; v.ar_d = ard; v.r_d = rdd;
        v.resp = rs; v.rd = rd; v.exp_rdata = er; v.exp_code = ec; v.exp_lat = el;
        return v;
    endfunction
    // Reference: each phase takes one cycle plus the slave's stall; the result mirrors what the slave returned
    function automatic vec_t model(vec_t v);
        vec_t r = v;
        int m = v.aw_d > v.w_d ? v.aw_d : v.w_d;
        r.exp_rdata = v.write ? 32'h0 : v.rd;
        r.exp_code  = v.resp;
        r.exp_lat   = v.write ? 2 + m + v.b_d : 2 + v.ar_d + v.r_d;
        return r;
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Called and returns at a negedge; acts as the slave and checks the master every cycle
    task automatic run_txn(input vec_t v);
        bit aw_done = 0, w_done = 0, ar_done = 0, b_sent = 0, r_sent = 0, got = 0;
        int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
        int p1 = v.write ? (v.aw_d > v.w_d ? v.aw_d : v.w_d) : v.ar_d;
        int p2 = v.write ? v.b_d : v.r_d;
        int k;
        bit hang_now;
        chk("cmd_ready", cmd_ready, 1);
        cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wd; cmd_wstrb = v.ws;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        for (k = 0; k < 100; k++) begin
            if (resp_valid) begin
                got = 1;
                break;
            end
            hang_now = hang_model || ((k < p1 ? k : p1) >= TMO) || (k > p1 && k - 1 - p1 >= TMO);
            chk("hang_wait", hang, hang_now);
            chk("busy", busy, 1);
            chk("awvalid", awvalid, v.write && !aw_done);
            chk("wvalid", wvalid, v.write && !w_done);
            chk("arvalid", arvalid, !v.write && !ar_done);
            chk("bready", bready, v.write && aw_done && w_done);
            chk("rready", rready, !v.write && ar_done);
            if (v.write && !aw_done) chk("awaddr", awaddr, v.addr);
            if (v.write && !w_done) chk("wdata", {wstrb, wdata}, {v.ws, v.wd});
            if (!v.write && !ar_done) chk("araddr", araddr, v.addr);
            awready = v.write && !aw_done && aw_c >= v.aw_d;
            wready  = v.write && !w_done && w_c >= v.w_d;
            arready = !v.write && !ar_done && ar_c >= v.ar_d;
            bvalid  = v.write && aw_done && w_done && !b_sent && b_c >= v.b_d;
            rvalid  = !v.write && ar_done && !r_sent && r_c >= v.r_d;
            bresp = v.resp; rresp = v.resp; rdata = v.rd;
            if (aw_done && w_done) b_c++;
            if (ar_done) r_c++;
            if (!aw_done) aw_c++;
            if (!w_done) w_c++;
            if (!ar_done) ar_c++;
            aw_done = aw_done || awready;
            w_done  = w_done || wready;
            ar_done = ar_done || arready;
            b_sent  = b_sent || bvalid;
            r_sent  = r_sent || rvalid;
            @(posedge clk);
            @(negedge clk);
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        end
        if (!got) chk("resp_timeout", 0, 1);
        hang_model = hang_model || p1 >= TMO || p2 >= TMO;
        chk("latency", k, v.exp_lat);
        chk("resp_rdata", resp_rdata, v.exp_rdata);
        chk("resp_code", resp_code, v.exp_code);
        chk("hang_done", hang, hang_model);
        chk("ready_in_resp", cmd_ready, 1);
    endtask
    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end
    initial begin
        vec_t tbl[6];
        vec_t v;
        tbl[0] = mk(1, 32'h4, 32'hA5A5_A5A5, 4'b0001, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b00, 2);
        tbl[1] = mk(1, 32'h8, 32'h1234_5678, 4'b1111, 3, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b00, 5);
        tbl[2] = mk(0, 32'h10, 32'h0, 4'b0000, 0, 0, 0, 0, 5, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 7);
        tbl[3] = mk(1, 32'h20, 32'hFFFF_0000, 4'b1100, 0, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 2'b10, 2);
        tbl[4] = mk(0, 32'h24, 32'h0, 4'b0000, 0, 0, 0, 2, 1, 2'b11, 32'h1234_5678, 32'h1234_5678, 2'b11, 5);
        tbl[5] = mk(1, 32'h30, 32'h0BAD_F00D, 4'b0110, 1, 2, 2, 0, 0, 2'b01, 32'h0, 32'h0, 2'b01, 6);
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, resp_valid, hang}, 0);
        chk("rst_resp", {resp_code, resp_rdata}, 0);
        chk("rst_addr", {awaddr, araddr}, 0);
        chk("rst_wdata", {wstrb, wdata}, 0);
        chk("rst_prot", {awprot, arprot}, 0);
        reset = 1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) run_txn(tbl[i]);
        for (int i = 0; i < 40; i++) begin
            v.write = 1'($urandom_range(0, 1));
            v.addr = $urandom; v.wd = $urandom; v.ws = 4'($urandom);
            v.aw_d = $urandom_range(0, 5); v.w_d = $urandom_range(0, 5); v.b_d = $urandom_range(0, 5);
            v.ar_d = $urandom_range(0, 5); v.r_d = $urandom_range(0, 5);
            v.resp = 2'($urandom); v.rd = $urandom;
            run_txn(model(v));
        end
        chk("hang_before_wdog", hang, 0);
        run_txn(mk(0, 32'h44, 32'h0, 4'b0000, 0, 0, 0, 20, 0, 2'b00, 32'hCAFE_0001, 32'hCAFE_0001, 2'b00, 22));
        run_txn(mk(1, 32'h48, 32'h5555_AAAA, 4'b1010, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b00, 2));
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h7777_7777; cmd_wstrb = 4'hF;
        awready = 1; wready = 1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        chk("mid_awvalid", {awvalid, wvalid}, 2'b11);
        @(posedge clk);
        @(negedge clk);
        awready = 0; wready = 0;
        chk("mid_bready", bready, 1);
        chk("mid_hang_sticky", hang, 1);
        bvalid = 1; bresp = 2'b00; reset = 0;
        @(posedge clk);
        @(negedge clk);
        bvalid = 0;
        chk("abort_valids", {awvalid, wvalid, arvalid, bready, rready, resp_valid}, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_hang", hang, 0);
        reset = 1;
        hang_model = 0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_no_resp", resp_valid, 0);
        run_txn(tbl[0]);
        @(negedge clk);
        chk("resp_one_cycle", resp_valid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
